// File: rtl/usb_arb_pkg.sv
// Shared types and widths for the USB line arbiter.
package usb_arb_pkg;

  // Ownership states of the shared D+/D- pair.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_H = 2'd1,
    GRANT_D = 2'd2,
    TURN    = 2'd3
  } arb_state_t;

  // Decoded line state; SE1 folds into K.
  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_J   = 2'd1,
    LS_K   = 2'd2
  } line_state_t;

  localparam int SE0_CNT_W    = 2;
  localparam int RSP_TMR_W    = 8;
  localparam int BABBLE_CNT_W = 11;
  localparam int TA_CNT_W     = 4;

  // Map sampled D+/D- to a line state for the selected speed polarity.
  function automatic line_state_t decode_line(input logic p, input logic m,
                                              input logic fullspeed);
    line_state_t ls;
    if (!p && !m) ls = LS_SE0;
    else if (fullspeed ? (p && !m) : (!p && m)) ls = LS_J;
    else ls = LS_K;
    return ls;
  endfunction

endpackage

// File: rtl/usb_linestate_decode.sv
// Line-state decoder: SE0 run counter and EOP detection (SE0 run >= 2 then J).
// eop_det is the same-cycle detection used by the arbiter FSM; eop is its
// registered copy, which is what leaves the block as the eop pulse.
module usb_linestate_decode
  import usb_arb_pkg::*;
#(
  parameter bit FULLSPEED = 1'b1
) (
  input  logic clk,
  input  logic nreset,
  input  logic linep,
  input  logic linem,
  input  logic clr,
  input  logic en,
  output logic eop_det,
  output logic eop
);

  line_state_t            line_state;
  logic [SE0_CNT_W-1:0]   se0_cnt;

  assign line_state = decode_line(linep, linem, FULLSPEED);
  assign eop_det    = en && !clr && (line_state == LS_J) && (se0_cnt >= 2'd2);

  // Saturating SE0 run counter, held at 0 outside a grant.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      se0_cnt <= '0;
    end else if (clr || !en) begin
      se0_cnt <= '0;
    end else if (line_state == LS_SE0) begin
      if (se0_cnt != 2'd3) se0_cnt <= se0_cnt + 2'd1;
    end else begin
      se0_cnt <= '0;
    end
  end

  // Registered one-cycle EOP strobe.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) eop <= 1'b0;
    else         eop <= eop_det;
  end

endmodule

// File: rtl/usb_line_arbiter.sv
// USB D+/D- ownership arbiter: one drive grant at a time, release on EOP,
// turnaround gap, and device response timer after each host packet.
// Optional babble detector enabled by defining USB_BABBLE_DET_EN.
//
// Request/grant: a requester holds its req high for as long as it wants the
// line; the grant rises one cycle after req is sampled in IDLE and falls one
// cycle after EOP, a req drop (abort) or babble. Grants are never both high.
module usb_line_arbiter
  import usb_arb_pkg::*;
#(
  parameter bit          FULLSPEED    = 1'b1,
  parameter int unsigned TA_BITS      = 2,
  parameter int unsigned TIMEOUT_BITS = 18,
  parameter int unsigned MAX_PKT_BITS = 1200
) (
  input  logic clk,
  input  logic nreset,
  input  logic host_req,
  input  logic dev_req,
  input  logic linep,
  input  logic linem,
  output logic host_gnt,
  output logic dev_gnt,
  output logic eop,
  output logic rsp_timeout,
  output logic babble
);

  localparam logic [TA_CNT_W-1:0]  TA_LAST = TA_CNT_W'(TA_BITS - 1);
  localparam logic [RSP_TMR_W-1:0] TMO_END = RSP_TMR_W'(TIMEOUT_BITS);

  arb_state_t             state, state_nxt;
  logic [TA_CNT_W-1:0]    ta_cnt;
  logic [RSP_TMR_W-1:0]   rsp_tmr;
  logic                   rsp_armed;
  logic                   in_grant, grant_entry, eop_det, babble_hit;

  assign in_grant    = (state == GRANT_H) || (state == GRANT_D);
  assign grant_entry = (state == IDLE) && (host_req || dev_req);

  usb_linestate_decode #(.FULLSPEED(FULLSPEED)) u_decode (
    .clk     (clk),
    .nreset  (nreset),
    .linep   (linep),
    .linem   (linem),
    .clr     (grant_entry),
    .en      (in_grant),
    .eop_det (eop_det),
    .eop     (eop)
  );

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: host priority in IDLE, EOP beats abort/babble.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (host_req)     state_nxt = GRANT_H;
        else if (dev_req) state_nxt = GRANT_D;
      end
      GRANT_H: if (eop_det || !host_req || babble_hit) state_nxt = TURN;
      GRANT_D: if (eop_det || !dev_req || babble_hit)  state_nxt = TURN;
      TURN:    if (ta_cnt == TA_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered grants derived from the next state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      host_gnt <= 1'b0;
      dev_gnt  <= 1'b0;
    end else begin
      host_gnt <= (state_nxt == GRANT_H);
      dev_gnt  <= (state_nxt == GRANT_D);
    end
  end

  // Turnaround counter, counts TURN cycles from 0.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)             ta_cnt <= '0;
    else if (state != TURN)  ta_cnt <= '0;
    else                     ta_cnt <= ta_cnt + 1'b1;
  end

  // Response timer: arms on host EOP, disarms silently on any grant entry.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rsp_tmr     <= '0;
      rsp_armed   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_timeout <= 1'b0;
      if (grant_entry) begin
        rsp_armed <= 1'b0;
      end else if ((state == GRANT_H) && eop_det) begin
        rsp_armed <= 1'b1;
        rsp_tmr   <= '0;
      end else if (rsp_armed && ((state == TURN) || (state == IDLE))) begin
        if (rsp_tmr == TMO_END) begin
          rsp_timeout <= 1'b1;
          rsp_armed   <= 1'b0;
        end else begin
          rsp_tmr <= rsp_tmr + 1'b1;
        end
      end
    end
  end

`ifdef USB_BABBLE_DET_EN
  logic [BABBLE_CNT_W-1:0] bab_cnt;

  assign babble_hit = in_grant && !eop_det &&
                      (bab_cnt == BABBLE_CNT_W'(MAX_PKT_BITS - 1));

  // Babble counter: granted cycles since entry; forced release at the limit.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bab_cnt <= '0;
      babble  <= 1'b0;
    end else begin
      babble <= babble_hit;
      if (!in_grant) bab_cnt <= '0;
      else           bab_cnt <= bab_cnt + 1'b1;
    end
  end
`else
  assign babble_hit = 1'b0;
  assign babble     = 1'b0;
`endif

endmodule

// File: tb/tb_usb_line_arbiter.sv
// Directed bench for usb_line_arbiter (FULLSPEED=1, TA_BITS=2,
// TIMEOUT_BITS=18, MAX_PKT_BITS=64). Expected output changes are queued as
// {cycle, host_gnt, dev_gnt, eop, rsp_timeout, babble}; a negedge monitor
// pops one entry every time the output vector changes.
module tb_usb_line_arbiter;

  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] L0 = 2'b00;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic host_req = 1'b0;
  logic dev_req = 1'b0;
  logic linep = 1'b1;
  logic linem = 1'b0;
  logic host_gnt, dev_gnt, eop, rsp_timeout, babble;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [20:0] exp_q[$];
  logic [4:0]  prev_vec = 5'b0;

  usb_line_arbiter #(
    .FULLSPEED    (1'b1),
    .TA_BITS      (2),
    .TIMEOUT_BITS (18),
    .MAX_PKT_BITS (64)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .host_req    (host_req),
    .dev_req     (dev_req),
    .linep       (linep),
    .linem       (linem),
    .host_gnt    (host_gnt),
    .dev_gnt     (dev_gnt),
    .eop         (eop),
    .rsp_timeout (rsp_timeout),
    .babble      (babble)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] pm);
    tick();
    {linep, linem} = pm;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_at(input int c, input logic [4:0] v);
    logic [31:0] cv;
    cv = c;
    exp_q.push_back({cv[15:0], v});
  endtask

  // Monitor: every output change must match the next queued expectation.
  always @(negedge clk) begin
    logic [4:0]  vec;
    logic [20:0] e;
    logic [31:0] cv;
    vec = {host_gnt, dev_gnt, eop, rsp_timeout, babble};
    cv  = cyc;
    if (vec !== prev_vec) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cycle=%0d got=%b want=no change", cyc, vec);
      end else begin
        e = exp_q.pop_front();
        if (e !== {cv[15:0], vec})
          begin
            bad++;
            $display("FAIL out_change got cycle=%0d vec=%b want cycle=%0d vec=%b",
                     cyc, vec, e[20:5], e[4:0]);
          end
      end
    end
    prev_vec = vec;
  end

  initial begin
    int n, g, d, e;

    // Reset state.
    repeat (2) tick();
    total++;
    if ({host_gnt, dev_gnt, eop, rsp_timeout, babble} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000",
               {host_gnt, dev_gnt, eop, rsp_timeout, babble});
    end
    nreset = 1'b1;
    tick();

    // Priority, host EOP, turnaround to device, device EOP.
    tick(); n = cyc; host_req = 1'b1; dev_req = 1'b1;
    expect_at(n + 1, 5'b10000);
    step(LK); step(LJ); step(L0); step(L0); step(LJ);
    g = cyc;
    expect_at(g + 1, 5'b00100);
    expect_at(g + 2, 5'b00000);
    expect_at(g + 4, 5'b01000);
    wait_to(g + 1); host_req = 1'b0;
    wait_to(g + 3);
    step(LK); step(L0); step(L0); step(LJ);
    d = cyc;
    expect_at(d + 1, 5'b00100);
    expect_at(d + 2, 5'b00000);
    wait_to(d + 1); dev_req = 1'b0;
    wait_to(d + 6);

    // Single SE0 is not EOP; later EOP arms the timer, which expires.
    tick(); n = cyc; host_req = 1'b1;
    expect_at(n + 1, 5'b10000);
    step(LK); step(L0); step(LJ); step(LK); step(L0); step(L0); step(LJ);
    e = cyc + 1;
    expect_at(e, 5'b00100);
    expect_at(e + 1, 5'b00000);
    expect_at(e + 19, 5'b00010);
    expect_at(e + 20, 5'b00000);
    wait_to(e); host_req = 1'b0;
    wait_to(e + 24);

    // Three-cycle SE0 EOP; device grant at e+11 cancels the timeout; device abort.
    tick(); n = cyc; host_req = 1'b1;
    expect_at(n + 1, 5'b10000);
    step(LK); step(L0); step(L0); step(L0); step(LJ);
    e = cyc + 1;
    expect_at(e, 5'b00100);
    expect_at(e + 1, 5'b00000);
    expect_at(e + 11, 5'b01000);
    expect_at(e + 13, 5'b00000);
    wait_to(e); host_req = 1'b0;
    wait_to(e + 10); dev_req = 1'b1;
    wait_to(e + 12); dev_req = 1'b0;
    wait_to(e + 40);

    // Host abort mid-packet: grant drops next cycle, no eop, no timer.
    tick(); n = cyc; host_req = 1'b1;
    expect_at(n + 1, 5'b10000);
    step(LK); step(L0); step(LK);
    host_req = 1'b0;
    expect_at(n + 4, 5'b00000);
    wait_to(n + 30);
    {linep, linem} = LJ;

    // Reset mid-grant drops the grant at once; IDLE afterwards.
    tick(); n = cyc; host_req = 1'b1;
    expect_at(n + 1, 5'b10000);
    step(LK); step(LK);
    step(LK);
    nreset = 1'b0; host_req = 1'b0;
    expect_at(n + 3, 5'b00000);
    wait_to(n + 5); nreset = 1'b1;
    wait_to(n + 6); host_req = 1'b1;
    expect_at(n + 7, 5'b10000);
    wait_to(n + 8); host_req = 1'b0;
    expect_at(n + 9, 5'b00000);
    wait_to(n + 14);

    // Constant K while granted: babble release at 64 cycles, or grant held.
    tick(); n = cyc; host_req = 1'b1; {linep, linem} = LK;
    expect_at(n + 1, 5'b10000);
`ifdef USB_BABBLE_DET_EN
    expect_at(n + 65, 5'b00001);
    expect_at(n + 66, 5'b00000);
    wait_to(n + 65); host_req = 1'b0;
    wait_to(n + 100);
`else
    wait_to(n + 81); host_req = 1'b0;
    expect_at(n + 82, 5'b00000);
    wait_to(n + 90);
`endif
    {linep, linem} = LJ;

    // Every queued expectation must have been consumed.
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_changes got=%0d pending want=0 next=%b",
               exp_q.size(), exp_q[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_line_arbiter.md
# usb_line_arbiter

Sequences ownership of the shared bidirectional USB D+/D- pair between a host-side and a device-side transceiver model. The arbiter sits between the two `usbModel` instances and the shared `linep`/`linem` nets. It issues one drive grant at a time and releases it on the packet EOP decoded from the line. It then enforces a bus-turnaround gap and times the device response to each host packet. It contains one clock domain, and each bit time is one `clk` cycle (12 MHz for full speed).

## Interface
Parameters:
- `FULLSPEED`, 1: J-state polarity. 1 means J = (linep=1, linem=0); 0 (low speed) means J = (0,1).
- `TA_BITS`, 2: turnaround gap in cycles after a grant release. Legal range is 1..15.
- `TIMEOUT_BITS`, 18: cycles allowed from host EOP until the device grant. Legal range is 1..255.
- `MAX_PKT_BITS`, 1200: babble limit in cycles per grant. Used only with `USB_BABBLE_DET_EN`.

Ports:
- `clk` input 1: bit clock.
- `nreset` input 1: asynchronous, active-low reset.
- `host_req` input 1: host requests to drive the line.
- `dev_req` input 1: device requests to drive the line.
- `linep` input 1: sampled D+.
- `linem` input 1: sampled D-.
- `host_gnt` output 1: host may drive.
- `dev_gnt` output 1: device may drive.
- `eop` output 1: one-cycle pulse marking the end of the granted packet.
- `rsp_timeout` output 1: one-cycle pulse when the device fails to respond in time.
- `babble` output 1: one-cycle pulse on a forced release. Tied to 0 without the macro.

## Operation
- Line state per cycle: SE0 = (0,0); J and K per `FULLSPEED`; SE1 = (1,1). SE1 is treated as K.
- The SE0 run counter is 2 bits and saturates at 3. It clears on any non-SE0 sample.
- EOP is the first J sample following an SE0 run of 2 or more. A run of 1 followed by J is not an EOP.
- States are IDLE, GRANT_H, GRANT_D and TURN.
- IDLE transitions:
  - `host_req` goes to GRANT_H.
  - Otherwise, `dev_req` goes to GRANT_D.
  - The host wins when both requests are present.
- GRANT_x transitions:
  - On EOP, pulse `eop` and go to TURN.
  - If the owner drops its request before EOP, go to TURN without `eop` (abort).
  - Requests from the non-owner are ignored.
- TURN waits `TA_BITS` cycles, ignores all requests, then goes to IDLE.
- The EOP detector runs only in GRANT states. The SE0 counter clears on entry to each GRANT state.
- Response timer:
  - An 8-bit timer arms on each host EOP and clears to 0 at that point.
  - It increments every cycle while in TURN or IDLE.
  - On reaching `TIMEOUT_BITS` it pulses `rsp_timeout` and disarms.
  - It disarms without a pulse on entry to GRANT_D or GRANT_H.
- `host_gnt` and `dev_gnt` are never both 1.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0, timer disarmed. Reset takes effect immediately, including mid-packet. Grants drop asynchronously.
- All outputs are registered.
- A request sampled in IDLE at cycle n gives a grant high in cycle n+1.
- The EOP J is sampled at cycle n. In cycle n+1, `eop` = 1 and the grant is 0. The grant can be reasserted no earlier than n+1+`TA_BITS`+1.
- After an abort (request low at cycle n), the grant is 0 at cycle n+1.
- `rsp_timeout` asserts in the cycle after the counter equals `TIMEOUT_BITS`, i.e. `TIMEOUT_BITS`+1 cycles after the `eop` pulse.
- If the timeout is reached in the same cycle as a GRANT_D entry, the grant wins and there is no timeout pulse.

## Configuration
- `USB_BABBLE_DET_EN` defined:
  - An 11-bit counter clears on GRANT entry and counts cycles in GRANT_x.
  - On reaching `MAX_PKT_BITS` without EOP, it pulses `babble`, releases the grant (next cycle) and goes to TURN.
  - Babble on a host grant does not arm the response timer.
- `USB_BABBLE_DET_EN` undefined: no counter is built, and `babble` is constant 0.

## Structure
- `usb_arb_pkg` holds:
  - the state enum (IDLE/GRANT_H/GRANT_D/TURN);
  - the line-state enum (SE0/J/K);
  - counter width constants (2-bit SE0 run, 8-bit timer, 11-bit babble).
- Sub-module `usb_linestate_decode`: maps `linep`/`linem` plus `FULLSPEED` to a line state, keeps the SE0 run counter, and produces a registered EOP strobe. It has a clear input driven on GRANT entry.
- The top level contains the FSM, the turnaround counter, the timeout timer and the optional babble counter.

## Test plan
- Priority: `host_req`=`dev_req`=1 in IDLE at cycle 10 → `host_gnt`=1 at cycle 11, `dev_gnt` stays 0.
- EOP and turnaround (`FULLSPEED`=1, `TA_BITS`=2): host drives K,J,SE0,SE0,J → `eop` and `host_gnt`=0 one cycle after the J. `dev_req` held high → `dev_gnt`=1 exactly 3 cycles later.
- Single-cycle SE0: SE0 then J while granted → no `eop`, grant held. A later SE0,SE0,J → `eop`.
- Timeout (`TIMEOUT_BITS`=18): host EOP with no `dev_req` → `rsp_timeout` pulse 19 cycles after `eop`. Repeat with `dev_req` at cycle 10 → no pulse.
- Abort and reset: drop `host_req` mid-packet → `host_gnt`=0 next cycle, no `eop`. `nreset` low mid-grant → grant 0 immediately, IDLE after release.
- With `USB_BABBLE_DET_EN`, `MAX_PKT_BITS`=64: constant K for 64 granted cycles → `babble` pulse and grant released next cycle. Without the macro → grant held and `babble`=0.
